design_select_ctrl: RTL and testbench

- Wishbone-slave controller that sits directly upstream of integrated_designs in user_project_wrapper and drives its design_select and a per-design reset.
- The management SoC selects the active student design by register write instead of raw LA bits.
- Every selection change runs a reset-hold sequence. During that sequence the selected design is held in reset and its GPIO outputs are forced to input (oeb=1), so no glitching design drives the pads.

---
 rtl/design_select_pkg.sv | 33 +++
 rtl/design_select_wb_regs.sv | 124 ++++++++++++
 rtl/design_select_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_design_select_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/design_select_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : design_select_pkg
//  Description : Shared types and constants for the design-select controller:
//                sequencer state encoding, Wishbone register offsets and
//                STATUS register bit positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package design_select_pkg;

   // Sequencer states. Encoding width is fixed so the state register size
   // does not depend on tool defaults.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      SETTLE = 2'd2
   } state_t;

   // Register offsets, taken from wbs_adr_i[3:2].
   localparam logic [1:0] c_reg_sel    = 2'd0;
   localparam logic [1:0] c_reg_status = 2'd1;
   localparam logic [1:0] c_reg_ctrl   = 2'd2;

   // STATUS register layout.
   localparam int c_status_busy    = 0;  // RO: sequencer not idle
   localparam int c_status_err     = 1;  // W1C: sticky invalid-select flag
   localparam int c_status_act_lsb = 4;  // RO: active select field LSB

   // CTRL register layout.
   localparam int c_ctrl_soft_rst  = 0;  // W: restart the reset-hold sequence

endpackage
`default_nettype wire

// File: rtl/design_select_wb_regs.sv
`default_nettype none
// ============================================================================
//  Module      : design_select_wb_regs
//  Description : Wishbone slave front end for the design-select controller.
//                Decodes the 16-byte register window, produces a single-cycle
//                registered ack, holds the SEL register and the sticky error
//                flag, and hands one-cycle write strobes to the sequencer.
//  Ports       : wbs_*        Wishbone slave interface
//                i_busy       sequencer busy, reported in STATUS
//                i_active_sel select currently driven to the designs
//                i_err_set    external request to set STATUS.err
//                o_sel_reg    SEL register contents
//                o_sel_wr     valid SEL write accepted this cycle
//                o_sel_wr_val value of that SEL write
//                o_soft_rst   CTRL soft-reset write accepted this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module design_select_wb_regs
   import design_select_pkg::*;
#(
   parameter int          SEL_W       = 4,
   parameter int          NUM_DESIGNS = 12,
   parameter logic [31:0] ADDR_BASE   = 32'h3000_0000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wbs_cyc_i,
   input  logic             wbs_stb_i,
   input  logic             wbs_we_i,
   input  logic [3:0]       wbs_sel_i,
   input  logic [31:0]      wbs_adr_i,
   input  logic [31:0]      wbs_dat_i,
   output logic             wbs_ack_o,
   output logic [31:0]      wbs_dat_o,
   input  logic             i_busy,
   input  logic [SEL_W-1:0] i_active_sel,
   input  logic             i_err_set,
   output logic [SEL_W-1:0] o_sel_reg,
   output logic             o_sel_wr,
   output logic [SEL_W-1:0] o_sel_wr_val,
   output logic             o_soft_rst
);

   logic             r_ack;
   logic [31:0]      r_dat;
   logic [SEL_W-1:0] r_sel;
   logic             r_err;

   logic             w_hit;
   logic             w_access;
   logic [1:0]       w_ofs;
   logic             w_wr;
   logic             w_rd;
   logic [SEL_W-1:0] w_wr_val;
   logic             w_val_ok;
   logic             w_sel_bad;
   logic             w_err_clr;
   logic [31:0]      w_rd_data;

   // Byte lanes 3..1, upper data bits and the byte offset carry nothing here.
   logic w_unused_bits;
   assign w_unused_bits = ^{wbs_sel_i[3:1], wbs_dat_i[31:SEL_W], wbs_adr_i[1:0]};

   assign w_hit    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == ADDR_BASE[31:4]);
   // An access is taken only while ack is low, so a strobe held high is
   // acknowledged every other cycle.
   assign w_access = w_hit & ~r_ack;
   assign w_ofs    = wbs_adr_i[3:2];
   assign w_wr     = w_access & wbs_we_i & wbs_sel_i[0];
   assign w_rd     = w_access & ~wbs_we_i;
   assign w_wr_val = wbs_dat_i[SEL_W-1:0];
   assign w_val_ok = (32'(w_wr_val) < NUM_DESIGNS);

   assign o_sel_wr     = w_wr & (w_ofs == c_reg_sel) & w_val_ok;
   assign o_sel_wr_val = w_wr_val;
   assign w_sel_bad    = w_wr & (w_ofs == c_reg_sel) & ~w_val_ok;
   assign w_err_clr    = w_wr & (w_ofs == c_reg_status) & wbs_dat_i[c_status_err];
   assign o_soft_rst   = w_wr & (w_ofs == c_reg_ctrl) & wbs_dat_i[c_ctrl_soft_rst];

   always_comb begin
      w_rd_data = '0;
      case (w_ofs)
         c_reg_sel: begin
            w_rd_data[SEL_W-1:0] = r_sel;
         end
         c_reg_status: begin
            w_rd_data[c_status_busy]                   = i_busy;
            w_rd_data[c_status_err]                    = r_err;
            w_rd_data[c_status_act_lsb +: SEL_W]       = i_active_sel;
         end
         default: begin
            w_rd_data = '0;  // CTRL and the reserved slot read as zero
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ack <= 1'b0;
         r_dat <= '0;
         r_sel <= '0;
         r_err <= 1'b0;
      end else begin
         r_ack <= w_access;
         // Read data is only non-zero in the ack cycle of a read.
         r_dat <= w_rd ? w_rd_data : 32'h0;
         if (o_sel_wr) begin
            r_sel <= w_wr_val;
         end
         // A new error in the same cycle as a clear keeps the flag set.
         if (w_sel_bad | i_err_set) begin
            r_err <= 1'b1;
         end else if (w_err_clr) begin
            r_err <= 1'b0;
         end
      end
   end

   assign wbs_ack_o = r_ack;
   assign wbs_dat_o = r_dat;
   assign o_sel_reg = r_sel;

endmodule
`default_nettype wire

// File: rtl/design_select_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : design_select_ctrl
//  Description : Selects the active student design from a Wishbone register
//                and runs a reset-hold sequence on every selection change:
//                the design is held in reset with its pads forced to input
//                for RST_CYCLES cycles, then released for one settle cycle
//                with pads still held, then fully released.
//  Ports       : clk, rst          system clock, async active-high reset
//                wbs_*             Wishbone slave interface
//                la_override_i     LA override request
//                la_sel_i          LA-supplied select
//                design_select_o   select to integrated_designs
//                design_rst_o      active-high reset to integrated_designs
//                gpio_hold_o       1 = wrapper forces all user io_oeb high
//  Options     : DESIGN_SEL_LA_OVERRIDE_EN - when defined, the synchronised
//                LA inputs may override the Wishbone select. When undefined
//                the LA inputs are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module design_select_ctrl
   import design_select_pkg::*;
#(
   parameter int          SEL_W       = 4,
   parameter int          NUM_DESIGNS = 12,
   parameter logic [31:0] ADDR_BASE   = 32'h3000_0000,
   parameter int          RST_CYCLES  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wbs_cyc_i,
   input  logic             wbs_stb_i,
   input  logic             wbs_we_i,
   input  logic [3:0]       wbs_sel_i,
   input  logic [31:0]      wbs_adr_i,
   input  logic [31:0]      wbs_dat_i,
   output logic             wbs_ack_o,
   output logic [31:0]      wbs_dat_o,
   input  logic             la_override_i,
   input  logic [SEL_W-1:0] la_sel_i,
   output logic [SEL_W-1:0] design_select_o,
   output logic             design_rst_o,
   output logic             gpio_hold_o
);

   localparam int                 c_cnt_w    = $clog2(RST_CYCLES) + 1;
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(RST_CYCLES - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

   state_t             r_state;
   logic [c_cnt_w-1:0] r_cnt;
   logic [SEL_W-1:0]   r_sel;
   logic               r_rst_o;
   logic               r_hold_o;

   logic               w_busy;
   logic [SEL_W-1:0]   w_sel_reg;
   logic               w_wb_sel_wr;
   logic [SEL_W-1:0]   w_wb_sel_val;
   logic               w_soft_rst;
   logic               w_err_set;

   logic               w_ovr;
   logic               w_ovr_edge;
   logic               w_la_ok;
   logic [SEL_W-1:0]   w_la_sel;

   logic [SEL_W-1:0]   w_target;
   logic               w_restart;
   logic               w_trigger;

   assign w_busy = (r_state != IDLE);

   design_select_wb_regs #(
      .SEL_W       (SEL_W),
      .NUM_DESIGNS (NUM_DESIGNS),
      .ADDR_BASE   (ADDR_BASE)
   ) u_regs (
      .clk          (clk),
      .rst          (rst),
      .wbs_cyc_i    (wbs_cyc_i),
      .wbs_stb_i    (wbs_stb_i),
      .wbs_we_i     (wbs_we_i),
      .wbs_sel_i    (wbs_sel_i),
      .wbs_adr_i    (wbs_adr_i),
      .wbs_dat_i    (wbs_dat_i),
      .wbs_ack_o    (wbs_ack_o),
      .wbs_dat_o    (wbs_dat_o),
      .i_busy       (w_busy),
      .i_active_sel (r_sel),
      .i_err_set    (w_err_set),
      .o_sel_reg    (w_sel_reg),
      .o_sel_wr     (w_wb_sel_wr),
      .o_sel_wr_val (w_wb_sel_val),
      .o_soft_rst   (w_soft_rst)
   );

`ifdef DESIGN_SEL_LA_OVERRIDE_EN
   logic             r_ovr_s1;
   logic             r_ovr_s2;
   logic             r_ovr_d;
   logic [SEL_W-1:0] r_la_s1;
   logic [SEL_W-1:0] r_la_s2;

   // Two-flop synchroniser for the LA inputs; r_ovr_d is one more stage
   // used only to spot override assert/deassert.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovr_s1 <= 1'b0;
         r_ovr_s2 <= 1'b0;
         r_ovr_d  <= 1'b0;
         r_la_s1  <= '0;
         r_la_s2  <= '0;
      end else begin
         r_ovr_s1 <= la_override_i;
         r_ovr_s2 <= r_ovr_s1;
         r_ovr_d  <= r_ovr_s2;
         r_la_s1  <= la_sel_i;
         r_la_s2  <= r_la_s1;
      end
   end

   assign w_ovr      = r_ovr_s2;
   assign w_ovr_edge = r_ovr_s2 ^ r_ovr_d;
   assign w_la_sel   = r_la_s2;
   assign w_la_ok    = (32'(r_la_s2) < NUM_DESIGNS);
   assign w_err_set  = r_ovr_s2 & ~w_la_ok;
`else
   logic w_unused_la;
   assign w_unused_la = ^{la_override_i, la_sel_i};

   assign w_ovr      = 1'b0;
   assign w_ovr_edge = 1'b0;
   assign w_la_sel   = '0;
   assign w_la_ok    = 1'b0;
   assign w_err_set  = 1'b0;
`endif

   // Work out the select the designs should see next and whether the
   // reset-hold sequence must (re)start this cycle. While the override is
   // active the LA value wins over any Wishbone write in the same cycle, and
   // an invalid LA code keeps the current select.
   always_comb begin
      w_target  = r_sel;
      w_restart = 1'b0;
      if (w_ovr) begin
         if (w_la_ok) begin
            w_target = w_la_sel;
         end
      end else if (w_wb_sel_wr) begin
         w_target  = w_wb_sel_val;
         // A rewrite of the same value only matters mid-sequence, where the
         // newest write restarts the count.
         w_restart = w_busy;
      end else begin
         w_target  = w_sel_reg;
      end
      w_trigger = w_restart | w_ovr_edge | w_soft_rst | (w_target != r_sel);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= HOLD;
         r_cnt    <= '0;
         r_sel    <= '0;
         r_rst_o  <= 1'b1;
         r_hold_o <= 1'b1;
      end else if (w_trigger) begin
         r_state  <= HOLD;
         r_cnt    <= '0;
         r_sel    <= w_target;
         r_rst_o  <= 1'b1;
         r_hold_o <= 1'b1;
      end else begin
         case (r_state)
            HOLD: begin
               // Compared before incrementing, so the counter never wraps.
               if (r_cnt == c_cnt_last) begin
                  r_state  <= SETTLE;
                  r_rst_o  <= 1'b0;
                  r_hold_o <= 1'b1;
               end else begin
                  r_cnt    <= r_cnt + c_cnt_one;
               end
            end
            SETTLE: begin
               r_state  <= IDLE;
               r_rst_o  <= 1'b0;
               r_hold_o <= 1'b0;
            end
            IDLE: begin
               r_rst_o  <= 1'b0;
               r_hold_o <= 1'b0;
            end
            default: begin
               r_state  <= IDLE;
               r_rst_o  <= 1'b0;
               r_hold_o <= 1'b0;
            end
         endcase
      end
   end

   assign design_select_o = r_sel;
   assign design_rst_o    = r_rst_o;
   assign gpio_hold_o     = r_hold_o;

endmodule
`default_nettype wire

// File: tb/tb_design_select_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_design_select_ctrl
//  Description : Self-checking bench for design_select_ctrl. Wishbone
//                accesses push their expected read data into a queue; a
//                monitor pops and compares on every ack. Reset-hold length
//                and settle length are counted per cycle by the monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_design_select_ctrl;

   localparam logic [31:0] c_base = 32'h3000_0000;

   logic        clk;
   logic        rst;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic        la_override_i;
   logic [3:0]  la_sel_i;
   logic [3:0]  design_select_o;
   logic        design_rst_o;
   logic        gpio_hold_o;

   int          total = 0;
   int          bad   = 0;
   int          rst_hi_cnt = 0;
   int          settle_cnt = 0;
   int          ack_cnt    = 0;
   logic [31:0] exp_q[$];

   design_select_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .wbs_cyc_i       (wbs_cyc_i),
      .wbs_stb_i       (wbs_stb_i),
      .wbs_we_i        (wbs_we_i),
      .wbs_sel_i       (wbs_sel_i),
      .wbs_adr_i       (wbs_adr_i),
      .wbs_dat_i       (wbs_dat_i),
      .wbs_ack_o       (wbs_ack_o),
      .wbs_dat_o       (wbs_dat_o),
      .la_override_i   (la_override_i),
      .la_sel_i        (la_sel_i),
      .design_select_o (design_select_o),
      .design_rst_o    (design_rst_o),
      .gpio_hold_o     (gpio_hold_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   // One sample per cycle, half a period away from the active edge.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (design_rst_o === 1'b1) rst_hi_cnt++;
         if (design_rst_o === 1'b0 && gpio_hold_o === 1'b1) settle_cnt++;
      end
      if (wbs_ack_o === 1'b1) begin
         ack_cnt++;
         if (exp_q.size() == 0) begin
            check_val("unexpected_ack", {31'b0, wbs_ack_o}, 32'h0);
         end else begin
            check_val("ack_data", wbs_dat_o, exp_q.pop_front());
         end
      end
   end

   task automatic clr_counts();
      rst_hi_cnt = 0;
      settle_cnt = 0;
   endtask

   task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                          input logic [3:0] sel, input bit exp_ack, input logic [31:0] exp_rd);
      int n;
      if (exp_ack) exp_q.push_back(we ? 32'h0 : exp_rd);
      @(negedge clk);
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = we;
      wbs_adr_i = adr;
      wbs_dat_i = dat;
      wbs_sel_i = sel;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (wbs_ack_o !== 1'b1 && n < 4);
      if (exp_ack) check_val("ack_seen", {31'b0, wbs_ack_o}, 32'h1);
      else         check_val("no_ack",   {31'b0, wbs_ack_o}, 32'h0);
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      wbs_we_i  = 1'b0;
   endtask

   task automatic wb_wr(input logic [1:0] ofs, input logic [31:0] dat);
      wb_xfer(c_base + {28'h0, ofs, 2'b00}, 1'b1, dat, 4'hF, 1'b1, 32'h0);
   endtask

   task automatic wb_rd(input logic [1:0] ofs, input logic [31:0] exp);
      wb_xfer(c_base + {28'h0, ofs, 2'b00}, 1'b0, 32'h0, 4'hF, 1'b1, exp);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((design_rst_o !== 1'b0 || gpio_hold_o !== 1'b0) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_val(tag, {30'b0, design_rst_o, gpio_hold_o}, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0;
      rst = 1'b1;
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
      la_override_i = 1'b0; la_sel_i = 4'h0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_sel",  {28'b0, design_select_o}, 32'h0);
      check_val("rst_drst", {31'b0, design_rst_o}, 32'h1);
      check_val("rst_hold", {31'b0, gpio_hold_o}, 32'h1);
      check_val("rst_ack",  {31'b0, wbs_ack_o}, 32'h0);
      check_val("rst_dat",  wbs_dat_o, 32'h0);
      rst = 1'b0;
      clr_counts();
      wait_idle("idle_after_rst");
      check_val("rel_rst_len", rst_hi_cnt, 16);
      check_val("rel_settle",  settle_cnt, 1);
      check_val("rel_sel",     {28'b0, design_select_o}, 32'h0);

      // Select design 5
      clr_counts();
      wb_wr(2'd0, 32'd5);
      check_val("sel5_on_ack", {28'b0, design_select_o}, 32'h5);
      check_val("sel5_drst",   {31'b0, design_rst_o}, 32'h1);
      wb_rd(2'd1, 32'h51);
      wait_idle("idle_sel5");
      check_val("sel5_rst_len", rst_hi_cnt, 16);
      check_val("sel5_settle",  settle_cnt, 1);
      wb_rd(2'd1, 32'h50);

      // Invalid selects set the sticky error, W1C clears it
      clr_counts();
      wb_wr(2'd0, 32'd13);
      repeat (3) @(posedge clk);
      #1;
      check_val("bad13_sel",  {28'b0, design_select_o}, 32'h5);
      check_val("bad13_hold", rst_hi_cnt, 0);
      wb_rd(2'd1, 32'h52);
      wb_wr(2'd1, 32'h2);
      wb_rd(2'd1, 32'h50);
      wb_wr(2'd0, 32'd12);
      wb_rd(2'd1, 32'h52);
      wb_wr(2'd1, 32'h2);
      wb_rd(2'd1, 32'h50);

      // Same value while idle and a write with byte lane 0 off do nothing
      clr_counts();
      wb_wr(2'd0, 32'd5);
      wb_xfer(c_base, 1'b1, 32'd4, 4'hE, 1'b1, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      check_val("noop_hold", rst_hi_cnt, 0);
      check_val("noop_sel",  {28'b0, design_select_o}, 32'h5);
      wb_rd(2'd0, 32'h5);

      // A second write on the 8th hold cycle restarts the count
      clr_counts();
      wb_wr(2'd0, 32'd3);
      repeat (7) @(posedge clk);
      wb_wr(2'd0, 32'd7);
      check_val("restart_sel", {28'b0, design_select_o}, 32'h7);
      wait_idle("idle_restart");
      check_val("restart_len",    rst_hi_cnt, 24);
      check_val("restart_settle", settle_cnt, 1);
      wb_rd(2'd0, 32'h7);

      // Soft reset keeps the select and reruns the sequence
      clr_counts();
      wb_wr(2'd2, 32'h1);
      wb_rd(2'd1, 32'h71);
      wait_idle("idle_soft");
      check_val("soft_len", rst_hi_cnt, 16);
      check_val("soft_sel", {28'b0, design_select_o}, 32'h7);
      wb_rd(2'd2, 32'h0);

      // Decode: outside the window no ack, reserved slot reads zero
      wb_xfer(32'h3000_0010, 1'b0, 32'h0, 4'hF, 1'b0, 32'h0);
      wb_xfer(32'h3000_0010, 1'b1, 32'd2, 4'hF, 1'b0, 32'h0);
      check_val("miss_sel", {28'b0, design_select_o}, 32'h7);
      wb_wr(2'd3, 32'hFFFF_FFFF);
      wb_rd(2'd3, 32'h0);

      // Strobe held for four cycles gives two acks
      a0 = ack_cnt;
      exp_q.push_back(32'h7);
      exp_q.push_back(32'h7);
      @(negedge clk);
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
      wbs_adr_i = c_base; wbs_sel_i = 4'hF;
      repeat (4) @(posedge clk);
      #1;
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      @(negedge clk);
      check_val("b2b_acks", ack_cnt - a0, 2);

      // Highest valid code
      wb_wr(2'd0, 32'd11);
      check_val("sel11", {28'b0, design_select_o}, 32'hB);
      wait_idle("idle_sel11");

      // Asynchronous reset in the middle of a hold sequence
      wb_wr(2'd0, 32'd8);
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_val("arst_sel",  {28'b0, design_select_o}, 32'h0);
      check_val("arst_drst", {31'b0, design_rst_o}, 32'h1);
      check_val("arst_hold", {31'b0, gpio_hold_o}, 32'h1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      clr_counts();
      wait_idle("idle_arst");
      check_val("arst_len", rst_hi_cnt, 16);
      wb_rd(2'd0, 32'h0);

`ifdef DESIGN_SEL_LA_OVERRIDE_EN
      // LA override takes over, WB writes only update the register
      clr_counts();
      @(negedge clk);
      la_sel_i = 4'd9;
      la_override_i = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check_val("la_sel9", {28'b0, design_select_o}, 32'h9);
      wait_idle("idle_la9");
      check_val("la9_len", rst_hi_cnt, 16);
      clr_counts();
      wb_wr(2'd0, 32'd2);
      repeat (3) @(posedge clk);
      #1;
      check_val("la_keep9",  {28'b0, design_select_o}, 32'h9);
      check_val("la_nohold", rst_hi_cnt, 0);
      wb_rd(2'd0, 32'h2);
      @(negedge clk);
      la_override_i = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check_val("la_rel_sel2", {28'b0, design_select_o}, 32'h2);
      wait_idle("idle_la_rel");
      check_val("la_rel_len", rst_hi_cnt, 16);
`else
      // LA inputs are ignored in this build
      clr_counts();
      @(negedge clk);
      la_sel_i = 4'd9;
      la_override_i = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check_val("la_ignored_sel",  {28'b0, design_select_o}, 32'h0);
      check_val("la_ignored_hold", rst_hi_cnt, 0);
      la_override_i = 1'b0;
`endif

      repeat (2) @(posedge clk);
      check_val("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
